// File: rtl/addr_dispatch_pkg.sv
// Shared types and constants for the FIFO read-side dispatcher:
// FSM state encoding, port geometry and the port-select decode helper.
package addr_dispatch_pkg;

    localparam int N_PORTS = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CAPT  = 3'd2,
        OFFER = 3'd3,
        STALL = 3'd4
    } state_e;

    function automatic logic [N_PORTS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [N_PORTS-1:0] one;
        one = {{(N_PORTS-1){1'b0}}, 1'b1};
        return one << sel;
    endfunction

endpackage

// File: rtl/addr_dispatch_sat_counter.sv
// Saturating up-counter used for the per-port delivered-word statistics.
// Holds at all-ones instead of wrapping; synchronous active-high clear.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] q_q;
    logic [CNT_W-1:0] q_d;

    // Next count: step once per accepted word unless already at the ceiling
    always_comb begin
        q_d = q_q;
        if (inc && (q_q != {CNT_W{1'b1}})) begin
            q_d = q_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            q_d = q_q;
        end
    end

    // Count register with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= {CNT_W{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/addr_dispatch.sv
// Pulls words from the address-decoder FIFO, routes each burst to the port named
// by its header's destination field and counts delivered words per port.
module addr_dispatch
    import addr_dispatch_pkg::*;
#(
    parameter int W_WIDTH  = 32,
    parameter int ADDR_LSB = 30,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    output logic                     fifo_en,
    output logic                     fifo_rd_en,
    input  logic [W_WIDTH-1:0]       fifo_data,
    input  logic                     fifo_empty,
    input  logic                     fifo_last,
    output logic [W_WIDTH-1:0]       port_data,
    output logic [N_PORTS-1:0]       port_valid,
    input  logic [N_PORTS-1:0]       port_ready,
    output logic                     burst_done,
    output logic [N_PORTS*CNT_W-1:0] cnt_flat
);

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 lock_q, lock_d;
    logic                 is_last_q, is_last_d;
    logic [W_WIDTH-1:0]   data_q, data_d;
    logic [N_PORTS-1:0]   valid_q, valid_d;
    logic                 rd_en_q, rd_en_d;
    logic                 done_q, done_d;

    logic                 can_fetch_s;
    logic                 transfer_s;
    logic [N_PORTS-1:0]   inc_s;

    assign can_fetch_s = en && !fifo_empty;
    assign transfer_s  = (state_q == OFFER) && port_ready[sel_q];

    // Next-state and datapath decisions; outputs are registered from the *_d values
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        lock_d    = lock_q;
        is_last_d = is_last_q;
        data_d    = data_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                lock_d = 1'b0;
                if (can_fetch_s) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                is_last_d = fifo_last;
                state_d   = CAPT;
            end
            CAPT: begin
                data_d = fifo_data;
                // Only the first word of a burst picks the port; body words follow the lock
                if (!lock_q) begin
                    sel_d  = fifo_data[ADDR_LSB +: SEL_W];
                    lock_d = 1'b1;
                end else begin
                    sel_d  = sel_q;
                end
                state_d = OFFER;
            end
            OFFER: begin
                if (transfer_s) begin
                    if (is_last_q) begin
                        done_d  = 1'b1;
                        lock_d  = 1'b0;
                        state_d = IDLE;
                    end else if (can_fetch_s) begin
                        state_d = FETCH;
                    end else begin
                        state_d = STALL;
                    end
                end else begin
                    state_d = OFFER;
                end
            end
            STALL: begin
                if (can_fetch_s) begin
                    state_d = FETCH;
                end else begin
                    state_d = STALL;
                end
            end
            default: begin
                lock_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        rd_en_d = (state_d == FETCH);
        if (state_d == OFFER) begin
            valid_d = sel_onehot(sel_d);
        end else begin
            valid_d = {N_PORTS{1'b0}};
        end
    end

    // State and output registers; reset discards any in-flight word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= {SEL_W{1'b0}};
            lock_q    <= 1'b0;
            is_last_q <= 1'b0;
            data_q    <= {W_WIDTH{1'b0}};
            valid_q   <= {N_PORTS{1'b0}};
            rd_en_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            lock_q    <= lock_d;
            is_last_q <= is_last_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            rd_en_q   <= rd_en_d;
            done_q    <= done_d;
        end
    end

    for (genvar p = 0; p < N_PORTS; p++) begin : g_cnt
        assign inc_s[p] = transfer_s && (sel_q == SEL_W'(p));

        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (inc_s[p]),
            .q   (cnt_flat[p*CNT_W +: CNT_W])
        );
    end

    assign fifo_en    = en;
    assign fifo_rd_en = rd_en_q;
    assign port_data  = data_q;
    assign port_valid = valid_q;
    assign burst_done = done_q;

endmodule

// File: tb/tb_addr_dispatch.sv
// Directed bench for addr_dispatch: a small FIFO model feeds two instances
// (16-bit and 2-bit counters) and hand-computed expectations are checked.
module tb_addr_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] fifo_data = 32'h0;
    logic        fifo_empty;
    logic        fifo_last;
    logic [3:0]  port_ready;

    logic        fifo_en, fifo_rd_en, burst_done;
    logic [31:0] port_data;
    logic [3:0]  port_valid;
    logic [63:0] cnt_flat;

    logic        s_fifo_en, s_fifo_rd_en, s_burst_done;
    logic [31:0] s_port_data;
    logic [3:0]  s_port_valid;
    logic [7:0]  s_cnt_flat;

    int tests  = 0;
    int failed = 0;
    int bd_cnt = 0;
    int rd_empty_viol = 0;

    logic [31:0] words [0:31];
    logic        lasts [0:31];
    int          rd_ptr = 0;
    int          wr_ptr = 0;

    always #5 clk = ~clk;

    addr_dispatch #(.W_WIDTH(32), .ADDR_LSB(30), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_en(fifo_en), .fifo_rd_en(fifo_rd_en),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_last(fifo_last),
        .port_data(port_data), .port_valid(port_valid), .port_ready(port_ready),
        .burst_done(burst_done), .cnt_flat(cnt_flat)
    );

    addr_dispatch #(.W_WIDTH(32), .ADDR_LSB(30), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .fifo_en(s_fifo_en), .fifo_rd_en(s_fifo_rd_en),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_last(fifo_last),
        .port_data(s_port_data), .port_valid(s_port_valid), .port_ready(port_ready),
        .burst_done(s_burst_done), .cnt_flat(s_cnt_flat)
    );

    // FIFO model: one-cycle read latency, last flag visible with the head entry
    always_comb begin
        fifo_empty = (rd_ptr == wr_ptr);
        fifo_last  = lasts[rd_ptr];
    end

    always @(posedge clk) begin
        if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
            fifo_data <= words[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (burst_done) bd_cnt <= bd_cnt + 1;
        if (fifo_rd_en && fifo_empty) rd_empty_viol <= rd_empty_viol + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w, input logic l);
        words[wr_ptr] = w;
        lasts[wr_ptr] = l;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_offer(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port_valid != 4'b0000) begin
                found = 1'b1;
                break;
            end
        end
        check_eq(tag, {63'd0, found}, 64'd1);
    endtask

    function automatic logic [15:0] cnt16(input logic [63:0] f, input int p);
        return f[p*16 +: 16];
    endfunction

    function automatic logic [1:0] cnt2(input logic [7:0] f, input int p);
        return f[p*2 +: 2];
    endfunction

    logic [31:0] exp_w [0:4];
    logic [31:0] held;

    initial begin
        rst = 1'b1;
        en = 1'b1;
        port_ready = 4'b0000;
        push(32'h8000_00AA, 1'b1);

        // Reset held with a non-empty FIFO and en high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
            check_eq("rst_valid", {60'd0, port_valid}, 64'd0);
        end
        check_eq("rst_cnt", cnt_flat, 64'd0);
        check_eq("rst_data", {32'd0, port_data}, 64'd0);
        check_eq("rst_done", {63'd0, burst_done}, 64'd0);
        check_eq("fifo_en_hi", {63'd0, fifo_en}, 64'd1);
        rst = 1'b0;

        // Single-word burst to port 2: exact latency
        @(negedge clk);
        check_eq("t1_rd_en_N", {63'd0, fifo_rd_en}, 64'd1);
        port_ready = 4'b0100;
        @(negedge clk);
        check_eq("t1_rd_en_N1", {63'd0, fifo_rd_en}, 64'd0);
        check_eq("t1_valid_N1", {60'd0, port_valid}, 64'd0);
        @(negedge clk);
        check_eq("t1_valid_N2", {60'd0, port_valid}, 64'h4);
        check_eq("t1_data", {32'd0, port_data}, 64'h8000_00AA);
        @(negedge clk);
        check_eq("t1_done_N3", {63'd0, burst_done}, 64'd1);
        check_eq("t1_valid_off", {60'd0, port_valid}, 64'd0);
        check_eq("t1_cnt2", {48'd0, cnt16(cnt_flat, 2)}, 64'd1);
        @(negedge clk);
        check_eq("t1_done_pulse", {63'd0, burst_done}, 64'd0);

        // Three-word burst: body address bits must not re-route
        port_ready = 4'b1111;
        exp_w[0] = 32'h4000_0001;
        exp_w[1] = 32'hC000_0002;
        exp_w[2] = 32'h0000_0003;
        push(exp_w[0], 1'b0);
        push(exp_w[1], 1'b0);
        push(exp_w[2], 1'b1);
        for (int i = 0; i < 3; i++) begin
            wait_offer("t2_offer");
            check_eq("t2_valid", {60'd0, port_valid}, 64'h2);
            check_eq("t2_data", {32'd0, port_data}, {32'd0, exp_w[i]});
            @(negedge clk);
            check_eq("t2_done", {63'd0, burst_done}, (i == 2) ? 64'd1 : 64'd0);
        end
        check_eq("t2_cnt1", {48'd0, cnt16(cnt_flat, 1)}, 64'd3);

        // Backpressure, then FIFO runs dry mid-burst
        port_ready = 4'b0000;
        push(32'h4000_0010, 1'b0);
        wait_offer("t3_offer");
        check_eq("t3_valid", {60'd0, port_valid}, 64'h2);
        held = port_data;
        port_ready = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t3_hold_valid", {60'd0, port_valid}, 64'h2);
            check_eq("t3_hold_data", {32'd0, port_data}, 64'h4000_0010);
            check_eq("t3_hold_rd", {63'd0, fifo_rd_en}, 64'd0);
        end
        port_ready = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t3_stall_valid", {60'd0, port_valid}, 64'd0);
            check_eq("t3_stall_rd", {63'd0, fifo_rd_en}, 64'd0);
        end
        push(32'h0000_0020, 1'b1);
        wait_offer("t3_refill");
        check_eq("t3_refill_valid", {60'd0, port_valid}, 64'h2);
        check_eq("t3_refill_data", {32'd0, port_data}, 64'h0000_0020);
        @(negedge clk);
        check_eq("t3_done", {63'd0, burst_done}, 64'd1);
        check_eq("t3_cnt1", {48'd0, cnt16(cnt_flat, 1)}, 64'd5);
        check_eq("t3_sat_cnt1", {62'd0, cnt2(s_cnt_flat, 1)}, 64'd3);

        // Reset while a word is offered and ready arrives in the same cycle
        port_ready = 4'b0000;
        push(32'hC000_0055, 1'b1);
        wait_offer("t4_offer");
        check_eq("t4_valid", {60'd0, port_valid}, 64'h8);
        rst = 1'b1;
        port_ready = 4'b1000;
        @(negedge clk);
        check_eq("t4_valid_rst", {60'd0, port_valid}, 64'd0);
        check_eq("t4_done_rst", {63'd0, burst_done}, 64'd0);
        check_eq("t4_cnt_rst", cnt_flat, 64'd0);
        rst = 1'b0;
        port_ready = 4'b0001;
        @(negedge clk);
        check_eq("t4_done_after", {63'd0, burst_done}, 64'd0);
        push(32'h0000_0077, 1'b1);
        wait_offer("t4_redecode");
        check_eq("t4_redecode_valid", {60'd0, port_valid}, 64'h1);
        check_eq("t4_redecode_data", {32'd0, port_data}, 64'h0000_0077);
        @(negedge clk);
        check_eq("t4_cnt0", {48'd0, cnt16(cnt_flat, 0)}, 64'd1);

        // en low blocks fetch; then five words to port 0 saturate the narrow counter
        rst = 1'b1;
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_w[i] = 32'h0000_0100 + i;
            push(exp_w[i], (i == 4));
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t5_en_low_rd", {63'd0, fifo_rd_en}, 64'd0);
        end
        check_eq("t5_fifo_en_lo", {63'd0, fifo_en}, 64'd0);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_offer("t5_offer");
            check_eq("t5_valid", {60'd0, port_valid}, 64'h1);
            check_eq("t5_data", {32'd0, port_data}, {32'd0, exp_w[i]});
            @(negedge clk);
            if (i == 4) check_eq("t5_done", {63'd0, burst_done}, 64'd1);
        end
        check_eq("t5_cnt0", {48'd0, cnt16(cnt_flat, 0)}, 64'd5);
        check_eq("t5_sat_cnt0", {62'd0, cnt2(s_cnt_flat, 0)}, 64'd3);

        @(negedge clk);
        check_eq("burst_done_total", bd_cnt, 64'd5);
        check_eq("rd_when_empty", rd_empty_viol, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
